// File: rtl/rab_cfg_pkg.sv
// Shared types and constants for the RAB slice configuration writer.
package rab_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] WORD_START  = 2'd0;
    localparam logic [1:0] WORD_END    = 2'd1;
    localparam logic [1:0] WORD_OFFSET = 2'd2;
    localparam logic [1:0] WORD_FLAGS  = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Sequence steps 0..4: disable, start, end, offset, flags.
    localparam logic [2:0] LAST_STEP = 3'd4;

    // Byte address of word k of slice s: base + (4*s + k)*4.
    function automatic logic [31:0] slice_word_addr(
        input logic [31:0] base,
        input logic [31:0] slice,
        input logic [1:0]  word
    );
        return base + {slice[27:0], word, 2'b00};
    endfunction

endpackage

// File: rtl/rab_slice_cfg_writer.sv
// Programs one RAB translation slice through five AXI-Lite writes, disabling it first.
// Optional B-channel timeout: define RAB_CFG_WRITER_TIMEOUT_EN.
module rab_slice_cfg_writer
    import rab_cfg_pkg::*;
#(
    parameter int          NUM_SLICES     = 32,
    parameter logic [31:0] CFG_BASE_ADDR  = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                                                   s_axi_aclk,
    input  logic                                                   s_axi_aresetn,
    input  logic                                                   req_valid_i,
    output logic                                                   req_ready_o,
    input  logic [((NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1)-1:0] req_slice_i,
    input  logic [31:0]                                            req_start_i,
    input  logic [31:0]                                            req_end_i,
    input  logic [31:0]                                            req_offset_i,
    input  logic [31:0]                                            req_flags_i,
    output logic [31:0]                                            m_axi_awaddr,
    output logic                                                   m_axi_awvalid,
    input  logic                                                   m_axi_awready,
    output logic [31:0]                                            m_axi_wdata,
    output logic [3:0]                                             m_axi_wstrb,
    output logic                                                   m_axi_wvalid,
    input  logic                                                   m_axi_wready,
    input  logic [1:0]                                             m_axi_bresp,
    input  logic                                                   m_axi_bvalid,
    output logic                                                   m_axi_bready,
    output logic                                                   done_o,
    output logic                                                   err_o
);

    localparam logic [31:0] NUM_SLICES_W = 32'(NUM_SLICES);

    state_e      r_state, w_state_nxt;
    logic [2:0]  r_step, w_step_nxt, w_step_inc;
    logic [31:0] r_slice, r_start, r_end, r_offset, r_flags;
    logic        r_ready, r_awvalid, r_wvalid, r_bready, r_done, r_err;
    logic [31:0] r_awaddr, r_wdata;
    logic        w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt, w_done_nxt, w_err_nxt;
    logic [31:0] w_awaddr_nxt, w_wdata_nxt;
    logic [31:0] w_slice_ext, w_seq_addr, w_seq_data;
    logic [1:0]  w_seq_word;
    logic        w_accept, w_slice_bad, w_aw_done, w_w_done, w_b_hs;

`ifdef RAB_CFG_WRITER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_tmo, w_tmo_nxt;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    assign w_slice_ext = 32'(req_slice_i);
    assign w_slice_bad = (w_slice_ext >= NUM_SLICES_W);
    assign w_accept    = req_valid_i & r_ready;
    assign w_aw_done   = ~r_awvalid | m_axi_awready;
    assign w_w_done    = ~r_wvalid | m_axi_wready;
    assign w_b_hs      = r_bready & m_axi_bvalid;
    assign w_step_inc  = r_step + 3'd1;

    // Address and data of the write that follows the current step.
    always_comb begin
        w_seq_word = WORD_FLAGS;
        w_seq_data = r_flags;
        case (w_step_inc)
            3'd1:    begin w_seq_word = WORD_START;  w_seq_data = r_start;  end
            3'd2:    begin w_seq_word = WORD_END;    w_seq_data = r_end;    end
            3'd3:    begin w_seq_word = WORD_OFFSET; w_seq_data = r_offset; end
            3'd4:    begin w_seq_word = WORD_FLAGS;  w_seq_data = r_flags;  end
            default: begin w_seq_word = WORD_FLAGS;  w_seq_data = r_flags & ~32'h1; end
        endcase
        w_seq_addr = slice_word_addr(CFG_BASE_ADDR, r_slice, w_seq_word);
    end

    // Next-state and next-output logic of the write sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_bready_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;
`ifdef RAB_CFG_WRITER_TIMEOUT_EN
        w_tmo_nxt     = r_tmo;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_slice_bad) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt   = ST_SEND;
                    w_step_nxt    = 3'd0;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_awaddr_nxt  = slice_word_addr(CFG_BASE_ADDR, w_slice_ext, WORD_FLAGS);
                    w_wdata_nxt   = req_flags_i & ~32'h1;
                    w_err_nxt     = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                w_awvalid_nxt = r_awvalid & ~m_axi_awready;
                w_wvalid_nxt  = r_wvalid & ~m_axi_wready;
                if (w_aw_done && w_w_done) begin
                    w_state_nxt  = ST_RESP;
                    w_bready_nxt = 1'b1;
`ifdef RAB_CFG_WRITER_TIMEOUT_EN
                    w_tmo_nxt    = 32'd0;
`endif
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_RESP: begin
                if (w_b_hs && (m_axi_bresp != RESP_OKAY)) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                end else if (w_b_hs && (r_step == LAST_STEP)) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                end else if (w_b_hs) begin
                    w_state_nxt   = ST_SEND;
                    w_step_nxt    = w_step_inc;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_awaddr_nxt  = w_seq_addr;
                    w_wdata_nxt   = w_seq_data;
`ifdef RAB_CFG_WRITER_TIMEOUT_EN
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_bready_nxt = 1'b1;
                    w_tmo_nxt    = r_tmo + 32'd1;
                end
`else
                end else begin
                    w_bready_nxt = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_state   <= ST_IDLE;
            r_step    <= 3'd0;
            r_ready   <= 1'b1;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_awaddr  <= 32'd0;
            r_wdata   <= 32'd0;
            r_bready  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_ready   <= (w_state_nxt == ST_IDLE);
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_bready  <= w_bready_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Request fields are captured once at accept and replayed by the sequence.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_slice  <= 32'd0;
            r_start  <= 32'd0;
            r_end    <= 32'd0;
            r_offset <= 32'd0;
            r_flags  <= 32'd0;
        end else if (w_accept) begin
            r_slice  <= w_slice_ext;
            r_start  <= req_start_i;
            r_end    <= req_end_i;
            r_offset <= req_offset_i;
            r_flags  <= req_flags_i;
        end
    end

`ifdef RAB_CFG_WRITER_TIMEOUT_EN
    // Counts RESP cycles spent waiting for the write response.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_tmo <= 32'd0;
        end else begin
            r_tmo <= w_tmo_nxt;
        end
    end
`endif

    assign req_ready_o   = r_ready;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign done_o        = r_done;
    assign err_o         = r_err;

endmodule

// File: tb/tb_rab_slice_cfg_writer.sv
// Directed bench for rab_slice_cfg_writer with a simple AXI-Lite slave model.
module tb_rab_slice_cfg_writer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_slice;
    logic [31:0] req_start, req_end, req_offset, req_flags;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready;
    logic        awready = 1'b0;
    logic        wready  = 1'b1;
    logic        bvalid  = 1'b0;
    logic [1:0]  bresp   = 2'b00;
    logic        done, err;

    int checks   = 0;
    int failures = 0;

    // slave model state; aw_delay/err_at/b_hold are set by the main sequence
    int          aw_delay = 0;
    int          err_at   = 0;
    bit          b_hold   = 1'b0;
    int          aw_hs_cnt = 0, done_cnt = 0, aw_cyc = 0, wv_cyc = 0, aw_unstable = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always #5 clk = ~clk;

    rab_slice_cfg_writer #(
        .NUM_SLICES    (20),
        .CFG_BASE_ADDR (32'h0000_0000),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rstn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_slice_i  (req_slice),
        .req_start_i  (req_start),
        .req_end_i    (req_end),
        .req_offset_i (req_offset),
        .req_flags_i  (req_flags),
        .m_axi_awaddr (awaddr),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata  (wdata),
        .m_axi_wstrb  (wstrb),
        .m_axi_wvalid (wvalid),
        .m_axi_wready (wready),
        .m_axi_bresp  (bresp),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (bready),
        .done_o       (done),
        .err_o        (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // AXI-Lite slave: acts at negedges; a handshake predicted at one negedge happened at the next posedge.
    initial begin
        bit          p_aw = 0, p_w = 0, p_b = 0, aw_got = 0, w_got = 0, prev_awv = 0;
        logic [31:0] p_addr = 0, p_data = 0, got_addr = 0, got_data = 0, prev_addr = 0;
        int          aw_wait = 0;
        forever begin
            @(negedge clk);
            wready = 1'b1;
            if (!rstn) begin
                bvalid = 1'b0; bresp = 2'b00; awready = 1'b0;
                aw_got = 0; w_got = 0; p_aw = 0; p_w = 0; p_b = 0; prev_awv = 0; aw_wait = 0;
            end else begin
                if (p_aw) begin aw_got = 1; got_addr = p_addr; aw_hs_cnt++; end
                if (p_w) begin w_got = 1; got_data = p_data; end
                if (p_b) begin bvalid = 1'b0; bresp = 2'b00; end
                if (aw_got && w_got && !bvalid && !b_hold) begin
                    wr_addr_q.push_back(got_addr);
                    wr_data_q.push_back(got_data);
                    bvalid = 1'b1;
                    bresp  = (wr_addr_q.size() == err_at) ? 2'b10 : 2'b00;
                    aw_got = 0; w_got = 0;
                end
                if (awvalid) begin
                    awready = (aw_wait >= aw_delay);
                    aw_wait++;
                    aw_cyc++;
                    if (prev_awv && (awaddr != prev_addr)) aw_unstable++;
                end else begin
                    awready = 1'b0;
                    aw_wait = 0;
                end
                if (wvalid) wv_cyc++;
                if (done) done_cnt++;
                p_aw = awvalid && awready; p_addr = awaddr;
                p_w  = wvalid && wready;   p_data = wdata;
                p_b  = bvalid && bready;
                prev_awv = awvalid; prev_addr = awaddr;
            end
        end
    end

    // Issue one request; lat is the cycle (accept cycle = 0) in which done_o is seen, -1 if never.
    task automatic do_req(input logic [4:0] sl, input logic [31:0] st, input logic [31:0] en,
                          input logic [31:0] off, input logic [31:0] fl, input int budget,
                          output int lat, output logic e);
        @(negedge clk);
        req_valid = 1'b1; req_slice = sl; req_start = st; req_end = en; req_offset = off; req_flags = fl;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        e = 1'b0;
        while (!done && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (done) e = err;
        else lat = -1;
    endtask

    logic [31:0] exp_addr[5] = '{32'h5C, 32'h50, 32'h54, 32'h58, 32'h5C};
    logic [31:0] exp_data[5] = '{32'h6, 32'h1000, 32'h1FFF, 32'h8000_0000, 32'h7};

    initial begin
        int   lat, log0, hs0, dn0, aw0, wv0;
        logic e;
        bit   found;
        rstn = 1'b0; req_valid = 1'b0; req_slice = 5'd0;
        req_start = 32'd0; req_end = 32'd0; req_offset = 32'd0; req_flags = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_bready", bready, 0);
        check_eq("rst_done_err", {done, err}, 0);
        rstn = 1'b1;

        // basic sequence, zero-wait slave
        log0 = wr_addr_q.size();
        do_req(5'd5, 32'h1000, 32'h1FFF, 32'h8000_0000, 32'h7, 100, lat, e);
        check_eq("basic_lat", lat, 11);
        check_eq("basic_err", e, 0);
        check_eq("basic_nwr", wr_addr_q.size() - log0, 5);
        check_eq("basic_wstrb", wstrb, 4'hF);
        for (int i = 0; i < 5; i++) begin
            if (log0 + i < wr_addr_q.size()) begin
                check_eq($sformatf("basic_addr%0d", i), wr_addr_q[log0 + i], exp_addr[i]);
                check_eq($sformatf("basic_data%0d", i), wr_data_q[log0 + i], exp_data[i]);
            end else begin
                check_eq($sformatf("basic_missing%0d", i), 0, 1);
            end
        end

        // awready delayed by 3 cycles on every write
        aw_delay = 3;
        log0 = wr_addr_q.size(); aw0 = aw_cyc; wv0 = wv_cyc;
        do_req(5'd5, 32'h1000, 32'h1FFF, 32'h8000_0000, 32'h7, 200, lat, e);
        aw_delay = 0;
        check_eq("awdly_lat", lat, 26);
        check_eq("awdly_err", e, 0);
        check_eq("awdly_awcyc", aw_cyc - aw0, 20);
        check_eq("awdly_wvcyc", wv_cyc - wv0, 5);
        check_eq("awdly_stable", aw_unstable, 0);
        check_eq("awdly_nwr", wr_addr_q.size() - log0, 5);
        if (wr_addr_q.size() == log0 + 5) begin
            for (int i = 0; i < 5; i++) begin
                check_eq($sformatf("awdly_addr%0d", i), wr_addr_q[log0 + i], exp_addr[i]);
                check_eq($sformatf("awdly_data%0d", i), wr_data_q[log0 + i], exp_data[i]);
            end
        end

        // SLVERR on write 2 aborts the sequence, slice stays disabled
        log0 = wr_addr_q.size(); hs0 = aw_hs_cnt;
        err_at = log0 + 2;
        do_req(5'd7, 32'hA000, 32'hAFFF, 32'h10, 32'h3, 100, lat, e);
        err_at = 0;
        check_eq("slverr_lat", lat, 5);
        check_eq("slverr_err", e, 1);
        check_eq("slverr_awhs", aw_hs_cnt - hs0, 2);
        if (wr_addr_q.size() == log0 + 2) begin
            check_eq("slverr_addr0", wr_addr_q[log0], 32'h7C);
            check_eq("slverr_data0", wr_data_q[log0], 32'h2);
            check_eq("slverr_addr1", wr_addr_q[log0 + 1], 32'h70);
        end else begin
            check_eq("slverr_nwr", wr_addr_q.size() - log0, 2);
        end

        // slice index out of range
        hs0 = aw_hs_cnt;
        do_req(5'd20, 32'h1, 32'h2, 32'h3, 32'h1, 50, lat, e);
        check_eq("badslice_lat", lat, 1);
        check_eq("badslice_err", e, 1);
        check_eq("badslice_awhs", aw_hs_cnt - hs0, 0);

        // reset while write 3 is in flight
        @(negedge clk);
        log0 = wr_addr_q.size(); hs0 = aw_hs_cnt; dn0 = done_cnt;
        req_valid = 1'b1; req_slice = 5'd2; req_start = 32'h1; req_end = 32'h2; req_offset = 32'h3; req_flags = 32'h1;
        @(negedge clk);
        req_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (wr_addr_q.size() >= log0 + 2 && awvalid) found = 1;
            else @(negedge clk);
        end
        check_eq("rstmid_reach_w3", found, 1);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("rstmid_awvalid", awvalid, 0);
        check_eq("rstmid_wvalid", wvalid, 0);
        check_eq("rstmid_bready", bready, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("rstmid_nodone", done_cnt - dn0, 0);
        check_eq("rstmid_awhs", aw_hs_cnt - hs0, 2);

        log0 = wr_addr_q.size();
        do_req(5'd5, 32'h1000, 32'h1FFF, 32'h8000_0000, 32'h7, 100, lat, e);
        check_eq("postrst_lat", lat, 11);
        check_eq("postrst_err", e, 0);
        check_eq("postrst_nwr", wr_addr_q.size() - log0, 5);
        if (wr_addr_q.size() == log0 + 5)
            check_eq("postrst_last", wr_data_q[log0 + 4], 32'h7);

`ifdef RAB_CFG_WRITER_TIMEOUT_EN
        // write response withheld: timeout after 255 RESP cycles
        b_hold = 1'b1;
        do_req(5'd1, 32'h1, 32'h2, 32'h3, 32'h1, 600, lat, e);
        check_eq("tmo_lat", lat, 257);
        check_eq("tmo_err", e, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rab_slice_cfg_writer.md
RAB_SLICE_CFG_WRITER -- requirements
Module: rab_slice_cfg_writer

Interface
REQ-001 SHALL have parameter NUM_SLICES, default 32, number of programmable translation slices.
REQ-002 SHALL have parameter CFG_BASE_ADDR, default 32'h0000_0000, byte address of slice 0 word 0 in the config register block.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, B-channel wait limit; used only under RAB_CFG_WRITER_TIMEOUT_EN.
REQ-004 SHALL have port s_axi_aclk, input, 1, sole clock.
REQ-005 SHALL have port s_axi_aresetn, input, 1; one clock, reset synchronous and active-low.
REQ-006 SHALL have port req_valid_i, input, 1, slice update request.
REQ-007 SHALL have port req_ready_o, output, 1, request accepted when high with req_valid_i.
REQ-008 SHALL have port req_slice_i, input, clog2(NUM_SLICES), target slice index.
REQ-009 SHALL have ports req_start_i, req_end_i, req_offset_i, input, 32 each, slice contents.
REQ-010 SHALL have port req_flags_i, input, 32, slice flags; bit 0 = enable.
REQ-011 SHALL have ports m_axi_awaddr (output, 32), m_axi_awvalid (output, 1), m_axi_awready (input, 1).
REQ-012 SHALL have ports m_axi_wdata (output, 32), m_axi_wstrb (output, 4), m_axi_wvalid (output, 1), m_axi_wready (input, 1).
REQ-013 SHALL have ports m_axi_bresp (input, 2), m_axi_bvalid (input, 1), m_axi_bready (output, 1).
REQ-014 SHALL have ports done_o (output, 1, one-cycle completion pulse) and err_o (output, 1, valid with done_o).

Function
REQ-015 SHALL sequence five AXI-Lite writes per request: word 3 = flags & ~1 (disable), word 0 = start, word 1 = end, word 2 = offset, word 3 = flags.
REQ-016 SHALL address word k of slice s at CFG_BASE_ADDR + (4*s + k)*4; wstrb always 4'hF.
REQ-017 SHALL use FSM states IDLE, SEND, RESP, DONE; IDLE->SEND on accept; SEND->RESP when AW and W both handshaken; RESP->SEND on OKAY bvalid with writes remaining; RESP->DONE on last OKAY or any error; DONE->IDLE unconditionally.
REQ-018 SHALL capture all request fields at accept; req_ready_o high only in IDLE.
REQ-019 SHALL assert awvalid and wvalid together on SEND entry and drop each independently after its own handshake; neither re-asserts until the next SEND.
REQ-020 SHALL hold awaddr/wdata stable while the corresponding valid is high.
REQ-021 SHALL assert m_axi_bready only in RESP.
REQ-022 SHALL treat bresp != 2'b00 as error: abort remaining writes, pulse done_o with err_o=1.
REQ-023 SHALL pulse done_o exactly one cycle in DONE; err_o=0 on success.
REQ-024 SHALL keep one write outstanding at most; minimum request latency 11 cycles with zero-wait slave (accept to done_o).
REQ-025 SHALL flag req_slice_i >= NUM_SLICES as error: no writes, DONE next cycle, err_o=1.

Reset
REQ-026 SHALL on s_axi_aresetn low at a clock edge enter IDLE, with req_ready_o=1 and awvalid, wvalid, bready, done_o, err_o all 0.
REQ-027 SHALL on reset mid-sequence drop all valids next edge, issue no further writes and produce no done_o pulse.

Configuration
REQ-028 SHALL, with RAB_CFG_WRITER_TIMEOUT_EN defined, count RESP cycles and after TIMEOUT_CYCLES cycles without bvalid go to DONE with err_o=1.
REQ-029 SHALL, without RAB_CFG_WRITER_TIMEOUT_EN, wait indefinitely in RESP and contain no timeout counter.

Structure
REQ-030 SHALL place the FSM state enum, word-index constants (START=0, END=1, OFFSET=2, FLAGS=3) and the OKAY code in shared package rab_cfg_pkg.
REQ-031 SHALL be a single module; no sub-module.

Verification
REQ-032 Slice 5, start 0x1000, end 0x1FFF, offset 0x8000_0000, flags 0x7, zero-wait slave -> writes 0x5C=0x6, 0x50=0x1000, 0x54=0x1FFF, 0x58=0x8000_0000, 0x5C=0x7; done_o at cycle 11, err_o=0.
REQ-033 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held with stable address until handshake; same final data.
REQ-034 bresp=2'b10 on write 2 -> no writes 3-5, done_o with err_o=1, slice left disabled.
REQ-035 req_slice_i=NUM_SLICES -> zero AW handshakes, done_o next-after-accept cycle, err_o=1.
REQ-036 Reset asserted during write 3 -> valids 0 next edge, no done_o; new request afterwards completes normally.
REQ-037 With RAB_CFG_WRITER_TIMEOUT_EN, bvalid withheld -> done_o, err_o=1 after 255 RESP cycles.
